// File: rtl/seq_shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// seq_shift_add_multiplier
//
// Unsigned sequential shift-add multiplier. One WIDTH-bit adder (carry-in 0)
// is reused once per cycle. Each RUN cycle adds the multiplicand to the high
// half of the partial product when the current multiplier bit is set. The
// sum and its carry-out are then shifted right by one into {hi, lo}. After
// WIDTH iterations {hi, lo} holds a*b.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset; overrides everything
//   start    in   operation request, sampled only while busy=0
//   a        in   [WIDTH-1:0]   multiplicand, captured on accepted start
//   b        in   [WIDTH-1:0]   multiplier, captured on accepted start
//   busy     out  high while an operation is in progress
//   done     out  one-cycle pulse on the edge that updates product
//   product  out  [2*WIDTH-1:0] a*b of the last completed operation
//
// Handshake: start is accepted at a rising edge where the block is idle.
// busy rises at that edge (k) and stays high for exactly WIDTH cycles.
// At edge k+WIDTH, busy falls, done pulses for one cycle and product
// updates. start seen while busy is dropped silently. start asserted in the
// done cycle is accepted, because the block is already idle then.
// ---------------------------------------------------------------------------
module seq_shift_add_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [CW-1:0]    count;

    // Adder stage: hi + (lo[0] ? mcand : 0).
    // The carry-out becomes the new MSB of hi, so no product bit is lost.
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] hi_next;
    logic [WIDTH-1:0] lo_next;

    always_comb begin
        addend  = lo[0] ? mcand : '0;
        sum     = {1'b0, hi} + {1'b0, addend};
        hi_next = sum[WIDTH:1];
        lo_next = {sum[0], lo[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            mcand   <= '0;
            hi      <= '0;
            lo      <= '0;
            count   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= a;
                        lo    <= b;
                        hi    <= '0;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    hi    <= hi_next;
                    lo    <= lo_next;
                    count <= count + CW'(1);
                    // On the final iteration the shifted value is complete.
                    // Publish it directly from the next-state terms.
                    if (count == LAST) begin
                        product <= {hi_next, lo_next};
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// Testbench for seq_shift_add_multiplier.
// A cycle-level reference model keeps a queue of pending a*b results and a
// countdown of remaining RUN cycles. Every negative edge, busy, done and
// product are compared against that model. Directed operations also check
// known constant products and the start-to-done latency.
// ---------------------------------------------------------------------------
module tb_seq_shift_add_multiplier;

    localparam int W = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT (WIDTH=4) ----------------
    logic           start = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    seq_shift_add_multiplier #(.WIDTH(W)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    // ---------------- DUT (WIDTH=8) ----------------
    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        busy8;
    logic        done8;
    logic [15:0] product8;

    seq_shift_add_multiplier #(.WIDTH(8)) u_dut8 (
        .clk     (clk),
        .rst     (rst),
        .start   (start8),
        .a       (a8),
        .b       (b8),
        .busy    (busy8),
        .done    (done8),
        .product (product8)
    );

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    logic [2*W-1:0] exp_q[$];
    int             rem      = 0;
    logic           exp_done = 1'b0;
    logic [2*W-1:0] held_exp = '0;
    logic           armed    = 1'b0;

    // Inputs change only on negedges, so they are stable here.
    always @(posedge clk) begin
        exp_done = 1'b0;
        if (rst) begin
            exp_q.delete();
            rem      = 0;
            held_exp = '0;
            armed    = 1'b1;
        end else if (rem == 0) begin
            if (start) begin
                exp_q.push_back({{W{1'b0}}, a} * {{W{1'b0}}, b});
                rem = W;
            end
        end else begin
            rem--;
            if (rem == 0) begin
                exp_done = 1'b1;
                if (exp_q.size() == 0) check("model_queue_empty", 1, 0);
                else                   held_exp = exp_q.pop_front();
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("busy",    busy,    rem != 0);
            check("done",    done,    exp_done);
            check("product", product, held_exp);
        end
    end

    // ---------------- driver tasks ----------------
    // Present one start pulse and return at the negedge after the edge
    // that accepted it.
    task automatic issue(input logic [W-1:0] xa, input logic [W-1:0] xb);
        @(negedge clk);
        start = 1'b1;
        a     = xa;
        b     = xb;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for done. lat0 is the number of cycles already spent
    // since acceptance.
    task automatic wait_done(input string tag, input logic [2*W-1:0] expv, input int lat0);
        int lat;
        lat = lat0;
        while (!done && lat < 3*W) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, W);
        check(tag, product, expv);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        logic [2*W-1:0] ref_p;

        repeat (2) @(negedge clk);
        check("reset_busy",    busy,    0);
        check("reset_done",    done,    0);
        check("reset_product", product, 0);
        rst = 1'b0;

        // Largest operands: exercises carry-out into hi.
        issue(4'hF, 4'hF);
        wait_done("f_x_f", 8'hE1, 0);

        issue(4'hA, 4'h3);
        wait_done("a_x_3", 8'h1E, 0);
        issue(4'h0, 4'hD);
        wait_done("0_x_d", 8'h00, 0);
        issue(4'h7, 4'h0);
        wait_done("7_x_0", 8'h00, 0);

        // Back-to-back: restart in the done cycle.
        issue(4'h5, 4'h6);
        wait_done("b2b_first", 8'h1E, 0);
        start = 1'b1;
        a     = 4'h9;
        b     = 4'h9;
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", busy, 1);
        check("b2b_hold", product, 8'h1E);
        wait_done("b2b_second", 8'h51, 0);

        // Start while busy is ignored.
        issue(4'h3, 4'h4);
        start = 1'b1;
        a     = 4'h1;
        b     = 4'h1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_ignore", 8'h0C, 1);
        for (int i = 0; i < W + 2; i++) begin
            @(negedge clk);
            check("no_extra_done", done, 0);
        end

        // Reset during the second RUN cycle aborts the operation.
        issue(4'hF, 4'hF);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy",    busy,    0);
        check("abort_done",    done,    0);
        check("abort_product", product, 0);
        for (int i = 0; i < W + 2; i++) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
        end
        issue(4'h2, 4'h3);
        wait_done("after_abort", 8'h06, 0);

        // Exhaustive operand sweep.
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                issue(W'(i), W'(j));
                ref_p = 8'(i * j);
                wait_done("sweep", ref_p, 0);
            end
        end

        // Random traffic with random starts, data, and occasional resets.
        // The reference model follows every cycle.
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            start = 1'($urandom_range(0, 1));
            a     = W'($urandom_range(0, 15));
            b     = W'($urandom_range(0, 15));
            rst   = ($urandom_range(0, 59) == 0);
        end
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        repeat (2*W) @(negedge clk);

        // WIDTH=8 instance: largest operands plus a few random ones.
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            start8 = 1'b1;
            a8     = (n == 0) ? 8'hFF : 8'($urandom_range(0, 255));
            b8     = (n == 0) ? 8'hFF : 8'($urandom_range(0, 255));
            @(negedge clk);
            start8 = 1'b0;
            lat    = 0;
            while (!done8 && lat < 24) begin
                @(negedge clk);
                lat++;
            end
            check("w8_latency", lat, 8);
            check("w8_product", product8, {8'h00, a8} * {8'h00, b8});
            if (n == 0) check("w8_ff_x_ff", product8, 16'hFE01);
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
